// File: rtl/fetch_stage.sv
// fifo2: two-entry synchronous FIFO with flush; head is a registered slot.
// Latency: a word pushed at the end of cycle N is visible at the head in N+1.
// Backpressure: pushes into a full FIFO without a pop, and pops when empty, are ignored.
module fifo2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         head_vld,
    output logic [W-1:0] head_dat,
    output logic [1:0]   occ
);
    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   count;
    logic         do_pop;
    logic         do_push;

    assign do_pop   = pop && (count != 2'd0);
    assign do_push  = push && ((count != 2'd2) || do_pop);
    assign head_vld = (count != 2'd0);
    assign head_dat = slot0;
    assign occ      = count;

    // Slot 0 is always the head; slot 1 shifts down on a pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_dat;
                    else               slot1 <= push_dat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_dat;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_dat;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// fetch_stage: owns the PC, drives imem, pairs returned words with their PC for decode.
// Latency: issue in N, memory word returns in N+1, pair at out_* in N+2; redirect target out in R+3.
// Backpressure: issue is throttled so FIFO occupancy plus in-flight never exceeds two entries.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc_plus4,
    output logic        fetch_fault
);
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    logic [31:0] pc_q;
    logic [31:0] pc_prev_q;
    logic        inflight_q;
    logic        fault_q;

    logic        legal;
    logic        target_legal;
    logic        pop;
    logic        issue;
    logic        push;
    logic [2:0]  demand;
    logic        head_vld;
    logic [63:0] head_dat;
    logic [1:0]  occ;

    assign legal        = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_PC);
    assign target_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);
    assign pop          = head_vld && out_ready;

    // Entries that will occupy the FIFO if nothing else happens; a pop is only
    // possible when occ is non-zero, so this never underflows.
    assign demand = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue  = legal && !fault_q && !redirect_valid && (demand <= 3'd1);

    // A redirect squashes the returning word: it belongs to the old path.
    assign push = inflight_q && !redirect_valid;

    // PC, in-flight tracking and sticky fault.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            pc_prev_q  <= 32'd0;
            inflight_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                pc_prev_q <= pc_q;
            end
            if (redirect_valid) begin
                pc_q <= redirect_pc;
            end else if (issue) begin
                pc_q <= pc_q + 32'd4;
            end
            // An illegal redirect keeps an existing fault rather than blipping it
            // low; a fresh illegal target is caught by the legality check next cycle.
            if (redirect_valid) begin
                fault_q <= fault_q && !target_legal;
            end else if (!legal) begin
                fault_q <= 1'b1;
            end
        end
    end

    fifo2 #(.W(64)) u_out_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push     (push),
        .push_dat ({pc_prev_q, imem_inst}),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .occ      (occ)
    );

    assign imem_pc      = pc_q;
    assign fetch_fault  = fault_q;
    assign out_valid    = head_vld;
    assign out_pc       = head_vld ? head_dat[63:32] : 32'd0;
    assign out_inst     = head_vld ? head_dat[31:0]  : 32'd0;
    assign out_pc_plus4 = head_vld ? head_dat[63:32] + 32'd4 : 32'd0;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: drives two fetch_stage instances (128-byte and 16-byte memories).
// Latency: expected PCs are queued as stimulus is applied, compared on each transfer.
// Backpressure: out_ready is toggled by the bench to exercise stalls.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] imem_pc, imem_inst, out_pc, out_inst, out_pc_plus4;
    logic        out_valid, fetch_fault;
    logic [31:0] imem_pc16, imem_inst16, out_pc16, out_inst16, out_pc_plus4_16;
    logic        out_valid16, fetch_fault16;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp16_q[$];
    bit          sel16 = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(128)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_pc_plus4   (out_pc_plus4),
        .fetch_fault    (fetch_fault)
    );

    fetch_stage #(.RESET_PC(32'h0), .IMEM_BYTES(16)) dut16 (
        .clk            (clk),
        .reset          (reset),
        .imem_pc        (imem_pc16),
        .imem_inst      (imem_inst16),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid16),
        .out_ready      (out_ready),
        .out_pc         (out_pc16),
        .out_inst       (out_inst16),
        .out_pc_plus4   (out_pc_plus4_16),
        .fetch_fault    (fetch_fault16)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {8'hC3, a[23:0]} ^ 32'h0055_AA00;
    endfunction

    // Registered instruction memory: word for the address seen at the previous edge.
    always @(posedge clk) begin
        imem_inst   <= word_of(imem_pc);
        imem_inst16 <= word_of(imem_pc16);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare any transfer happening this cycle, then advance one cycle.
    task automatic tick();
        logic [31:0] e;
        if (!sel16 && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", out_pc, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_pc", out_pc, e);
                check_eq("out_inst", out_inst, word_of(e));
                check_eq("out_pc_plus4", out_pc_plus4, e + 32'd4);
            end
        end
        if (sel16 && out_valid16 && out_ready) begin
            if (exp16_q.size() == 0) begin
                check_eq("spurious_out16", out_pc16, 32'hFFFF_FFFF);
            end else begin
                e = exp16_q.pop_front();
                check_eq("out_pc16", out_pc16, e);
                check_eq("out_inst16", out_inst16, word_of(e));
                check_eq("out_pc_plus4_16", out_pc_plus4_16, e + 32'd4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_imem_pc"}, imem_pc, 32'd0);
        check_eq({tag, "_fault"}, 32'(fetch_fault), 32'd0);
        check_eq({tag, "_out_pc"}, out_pc, 32'd0);
        check_eq({tag, "_out_inst"}, out_inst, 32'd0);
        check_eq({tag, "_plus4"}, out_pc_plus4, 32'd0);
    endtask

    // Hold reset for two edges; on return the bench sits in cycle 0.
    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_reset_state("rst");
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;

        // Streaming from reset: first pair in cycle 2, then one per cycle.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
        for (int c = 0; c < 7; c++) begin
            if (c < 4) check_eq($sformatf("t1_imem_pc_c%0d", c), imem_pc, 32'(4 * c));
            if (c < 2) check_eq($sformatf("t1_valid_c%0d", c), 32'(out_valid), 32'd0);
            if (c == 2) check_eq("t1_valid_c2", 32'(out_valid), 32'd1);
            tick();
        end
        check_eq("t1_drain", 32'(exp_q.size()), 32'd0);

        // Backpressure: FIFO fills with 0 and 4, PC stalls at 8, then resumes.
        do_reset();
        out_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        tick();
        tick();
        out_ready = 1'b0;
        for (int c = 2; c < 6; c++) begin
            check_eq($sformatf("t2_valid_c%0d", c), 32'(out_valid), 32'd1);
            check_eq($sformatf("t2_hold_pc_c%0d", c), out_pc, 32'd0);
            if (c >= 3) check_eq($sformatf("t2_stall_pc_c%0d", c), imem_pc, 32'h8);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 6; c < 10; c++) tick();
        out_ready = 1'b0;
        check_eq("t2_drain", 32'(exp_q.size()), 32'd0);

        // Redirect to 0x0C while pc_q=0x08: the pop of 0 still counts, 4/8 squashed.
        do_reset();
        out_ready = 1'b1;
        exp_q = '{32'h0, 32'hC, 32'h10, 32'h14};
        tick();
        tick();
        check_eq("t3_pc_before", imem_pc, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hC;
        tick();
        redirect_valid = 1'b0;
        check_eq("t3_target_pc", imem_pc, 32'hC);
        check_eq("t3_valid_r1", 32'(out_valid), 32'd0);
        tick();
        check_eq("t3_valid_r2", 32'(out_valid), 32'd0);
        tick();
        check_eq("t3_valid_r3", 32'(out_valid), 32'd1);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        check_eq("t3_drain", 32'(exp_q.size()), 32'd0);

        // Misaligned redirect faults; illegal redirect keeps it; legal one clears it.
        do_reset();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick();
        redirect_valid = 1'b0;
        check_eq("t4_pc_mis", imem_pc, 32'h6);
        check_eq("t4_fault_c1", 32'(fetch_fault), 32'd0);
        tick();
        check_eq("t4_fault_c2", 32'(fetch_fault), 32'd1);
        check_eq("t4_valid_c2", 32'(out_valid), 32'd0);
        tick();
        check_eq("t4_no_issue", imem_pc, 32'h6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check_eq("t4_pc_oor", imem_pc, 32'h200);
        check_eq("t4_fault_kept", 32'(fetch_fault), 32'd1);
        tick();
        check_eq("t4_fault_c5", 32'(fetch_fault), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        check_eq("t4_fault_cleared", 32'(fetch_fault), 32'd0);
        check_eq("t4_resume_pc0", imem_pc, 32'h0);
        exp_q = '{32'h0, 32'h4};
        tick();
        check_eq("t4_resume_pc4", imem_pc, 32'h4);
        tick();
        check_eq("t4_valid_back", 32'(out_valid), 32'd1);
        tick();
        tick();
        out_ready = 1'b0;
        check_eq("t4_drain", 32'(exp_q.size()), 32'd0);

        // End of a 16-byte memory: 0..0x0C delivered, 0x10 never issued, fault set.
        do_reset();
        sel16     = 1'b1;
        out_ready = 1'b1;
        exp16_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int c = 0; c < 9; c++) begin
            if (c == 4) begin
                check_eq("t5_pc_end", imem_pc16, 32'h10);
                check_eq("t5_fault_c4", 32'(fetch_fault16), 32'd0);
            end
            if (c >= 5) check_eq($sformatf("t5_fault_c%0d", c), 32'(fetch_fault16), 32'd1);
            tick();
        end
        check_eq("t5_drain", 32'(exp16_q.size()), 32'd0);
        check_eq("t5_pc_hold", imem_pc16, 32'h10);
        check_eq("t5_valid_end", 32'(out_valid16), 32'd0);
        out_ready = 1'b0;
        sel16     = 1'b0;

        // Mid-stream reset with the FIFO full: nothing stale comes out afterwards.
        do_reset();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        check_eq("t6_full_valid", 32'(out_valid), 32'd1);
        check_eq("t6_full_pc", imem_pc, 32'h8);
        reset = 1'b0;
        tick();
        check_reset_state("t6_mid_rst");
        reset     = 1'b1;
        out_ready = 1'b1;
        exp_q = '{32'h0, 32'h4, 32'h8};
        check_eq("t6_valid_c0", 32'(out_valid), 32'd0);
        tick();
        check_eq("t6_valid_c1", 32'(out_valid), 32'd0);
        tick();
        check_eq("t6_valid_c2", 32'(out_valid), 32'd1);
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        check_eq("t6_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end; sits directly upstream of the instruction memory.
- Owns the program counter and drives the byte address into the memory, which returns the word registered one cycle later.
- Pairs each returned word with its PC in a 2-entry output FIFO, handing pairs to decode over a valid/ready handshake.
- Handles branch/jump redirect (flush + squash) and flags out-of-range or misaligned fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_BYTES, 128, instruction memory size in bytes. Legal fetch PC range is 0..IMEM_BYTES-4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
- imem_pc  out  32  byte address presented to instruction memory; equals pc_q.
- imem_inst  in  32  word from memory; holds inst(imem_pc sampled at previous edge).
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head this cycle.
- out_pc  out  32  PC of head instruction.
- out_inst  out  32  head instruction word.
- out_pc_plus4  out  32  out_pc + 4, mod 2^32.
- fetch_fault  out  1  sticky fault: misaligned or out-of-range fetch PC.

Behaviour:
- Reset (reset==0 at edge): pc_q=RESET_PC; inflight=0; FIFO occupancy=0; fetch_fault=0; out_valid=0.
  - out_pc, out_inst and out_pc_plus4 read 0.
  - Any in-flight word is discarded.
  - Mid-operation reset behaves identically.
- legal = (pc_q[1:0]==0) && (pc_q <= IMEM_BYTES-4).
- pop = out_valid && out_ready.
- Issue, cycle N:
  - issue = legal && !fetch_fault && !redirect_valid && (occ + inflight - pop <= 1).
  - On issue: inflight_next=1 and pc_q_next=pc_q+4.
  - Otherwise: inflight_next=0 and pc_q holds.
- Return, cycle N+1: if inflight==1 and no redirect this cycle, write {pc_q_prev, imem_inst} into the FIFO tail at the end of N+1.
  - Entry is visible at the head in N+2.
  - Fetch-to-out_valid latency = 2 cycles.
  - Steady state with out_ready=1: one instruction per cycle.
- FIFO: depth 2, head drives the out_* ports.
  - The issue rule makes overflow impossible.
  - Simultaneous push and pop is allowed at occupancy 1 or 2.
  - Pop when empty is ignored.
  - Data is held stable while out_valid=1 and out_ready=0.
- Redirect (redirect_valid=1 at edge), all in the same edge:
  - A pop in the same cycle still counts as a transfer.
  - Then the FIFO is cleared, the in-flight word is squashed (never written), pc_q=redirect_pc, and no issue occurs that cycle.
  - Target appears on imem_pc in R+1 and is issued if legal.
  - Word returns in R+2 and out_valid=1 in R+3.
  - A redirect to a legal target clears fetch_fault.
- Fault: if !legal, no issue and fetch_fault=1 from the next cycle.
  - Fault is sticky until reset or a redirect to a legal target.
  - Already-buffered entries still drain normally.
  - Misaligned redirect_pc gives pc_q=target and fetch_fault=1 one cycle later, with no fetch.
- End of memory: after issuing IMEM_BYTES-4, pc_q=IMEM_BYTES becomes illegal and sets the fault. There is no wrap.
- Redirect while fault set: handled as a normal redirect; the fault clears only if the target is legal.

Test Plan:
- Reset release, out_ready=1, memory holding words W0..W4 at 0x00..0x10 -> imem_pc=0,4,8,... from cycle 0; out_valid first high in cycle 2 with out_pc=0, out_inst=W0, out_pc_plus4=4; then one pair per cycle.
- out_ready=0 from cycle 2 -> FIFO fills with PCs 0 and 4; imem_pc stalls at 8 with no further issue; out_pc=0 held stable; out_ready=1 resumes in-order delivery 0,4,8 with no loss or duplication.
- Streaming, redirect_valid=1 with redirect_pc=0x0C while pc_q=0x08 -> words for 0x04/0x08 are squashed; imem_pc=0x0C next cycle; next delivered out_pc=0x0C, out_valid high 3 cycles after the redirect.
- redirect_pc=0x06 -> no issue, fetch_fault=1 one cycle later; then redirect_pc=0x00 -> fetch_fault=0 and fetching resumes at 0x00.
- IMEM_BYTES=16, run from 0 -> PCs 0,4,8,0x0C are delivered; pc_q=0x10 never issued; fetch_fault=1.
- reset=0 for one cycle mid-stream with FIFO full -> next cycle out_valid=0 and imem_pc=RESET_PC; the stale in-flight word is never delivered.
